// File: rtl/clock_reset_sequencer_if.sv
// Control/status bundle between the PLL-side controller and the reset/enable sequencer.
// slave is the sequencer side; master drives lock and soft-reset requests.
interface clock_reset_sequencer_if #(
   parameter int NUM_CH = 2
);
   logic              locked;
   logic              soft_reset;
   logic [NUM_CH-1:0] reset_out;
   logic [NUM_CH-1:0] ce;
   logic [NUM_CH-1:0] tick;
   logic              ready;

   modport master (
      output locked, soft_reset,
      input  reset_out, ce, tick, ready
   );

   modport slave (
      input  locked, soft_reset,
      output reset_out, ce, tick, ready
   );
endinterface

// File: rtl/clock_reset_sequencer.sv
// Waits for PLL lock, stretches reset, then releases NUM_CH domains in staggered order with per-domain ce/tick.
// All outputs registered; lock loss or soft_reset returns every output to its reset value one edge later.
module clock_reset_sequencer #(
   parameter int                          NUM_CH         = 2,
   parameter int                          DIV_WIDTH      = 8,
   parameter logic [NUM_CH*DIV_WIDTH-1:0] DIVISORS       = {8'd1, 8'd1},
   parameter int                          RESET_CYCLES   = 32,
   parameter int                          STAGGER_CYCLES = 4
)(
   input  logic                  clk,
   input  logic                  reset,
   clock_reset_sequencer_if.slave bus
);
   localparam int HOLD_W  = $clog2(RESET_CYCLES + 1);
   localparam int STG_MAX = (NUM_CH - 1) * STAGGER_CYCLES;
   localparam int STG_W   = (STG_MAX < 1) ? 1 : $clog2(STG_MAX + 1);
   localparam bit INSTANT = (STG_MAX == 0);

   typedef enum logic [1:0] {WAIT_LOCK, HOLD, STAGGER, RUN} state_t;

   state_t            state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [STG_W-1:0]  stg_q, stg_d;
   logic [STG_W:0]    stg_inc;
   logic [NUM_CH-1:0] rst_q, rst_d;
   logic              ready_q, ready_d;
   logic              abort;
   logic [NUM_CH-1:0] ce_v, tick_v;

   assign abort   = bus.soft_reset | ~bus.locked;
   assign stg_inc = {1'b0, stg_q} + (STG_W + 1)'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= WAIT_LOCK;
         hold_q  <= '0;
         stg_q   <= '0;
         rst_q   <= '1;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         stg_q   <= stg_d;
         rst_q   <= rst_d;
         ready_q <= ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      stg_d   = stg_q;
      rst_d   = rst_q;
      ready_d = ready_q;
      case (state_q)
         WAIT_LOCK: begin
            hold_d  = '0;
            stg_d   = '0;
            rst_d   = '1;
            ready_d = 1'b0;
            if (bus.locked && !bus.soft_reset) state_d = HOLD;
         end
         HOLD: begin
            if (hold_q == HOLD_W'(RESET_CYCLES - 1)) begin
               stg_d = '0;
               if (INSTANT) begin
                  rst_d   = '0;
                  ready_d = 1'b1;
                  state_d = RUN;
               end else begin
                  rst_d[0] = 1'b0;
                  state_d  = STAGGER;
               end
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         STAGGER: begin
            // stg_inc counts edges since reset_out[0] fell, including this one
            stg_d = stg_inc[STG_W-1:0];
            for (int k = 1; k < NUM_CH; k++) begin
               if (stg_inc == (STG_W + 1)'(k * STAGGER_CYCLES)) rst_d[k] = 1'b0;
            end
            if (stg_inc == (STG_W + 1)'(STG_MAX)) begin
               ready_d = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            state_d = RUN;
         end
         default: state_d = WAIT_LOCK;
      endcase
      if (state_q != WAIT_LOCK && abort) begin
         state_d = WAIT_LOCK;
         hold_d  = '0;
         stg_d   = '0;
         rst_d   = '1;
         ready_d = 1'b0;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_div
      localparam logic [DIV_WIDTH-1:0] RAW = DIVISORS[i*DIV_WIDTH +: DIV_WIDTH];
      localparam logic [DIV_WIDTH-1:0] TOP = (RAW == '0) ? '0 : RAW - DIV_WIDTH'(1);

      logic [DIV_WIDTH-1:0] div_q;
      logic                 ce_r, tick_r;

      // rst_d covers the abort edge so the divider clears together with reset_out
      always_ff @(posedge clk) begin
         if (reset || rst_q[i] || rst_d[i]) begin
            div_q  <= '0;
            ce_r   <= 1'b0;
            tick_r <= 1'b0;
         end else if (div_q == TOP) begin
            div_q  <= '0;
            ce_r   <= 1'b1;
            tick_r <= ~tick_r;
         end else begin
            div_q  <= div_q + DIV_WIDTH'(1);
            ce_r   <= 1'b0;
         end
      end

      assign ce_v[i]   = ce_r;
      assign tick_v[i] = tick_r;
   end

   assign bus.reset_out = rst_q;
   assign bus.ce        = ce_v;
   assign bus.tick      = tick_v;
   assign bus.ready     = ready_q;
endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Bench for clock_reset_sequencer: two instances (staggered, and zero-stagger with a zero divisor)
// driven by the same lock/soft-reset stimulus, checked every edge against a timeline model.
module tb_clock_reset_sequencer;
   localparam int RC  = 8;
   localparam int STG = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   clock_reset_sequencer_if #(.NUM_CH(3)) bus_a ();
   clock_reset_sequencer_if #(.NUM_CH(3)) bus_b ();

   clock_reset_sequencer #(
      .NUM_CH(3), .DIV_WIDTH(8), .DIVISORS({8'd3, 8'd2, 8'd1}),
      .RESET_CYCLES(RC), .STAGGER_CYCLES(STG)
   ) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));

   clock_reset_sequencer #(
      .NUM_CH(3), .DIV_WIDTH(8), .DIVISORS({8'd3, 8'd2, 8'd0}),
      .RESET_CYCLES(RC), .STAGGER_CYCLES(0)
   ) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

   int vectors     = 0;
   int miscompares = 0;
   int edge_n      = 0;
   int start       = -1;   // edge index of E0 of the running sequence, -1 while waiting for lock

   function automatic int imax1(input int v);
      return (v < 1) ? 1 : v;
   endfunction

   task automatic chk_int(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Expected outputs follow from elapsed edges since E0 and each channel's release time.
   task automatic check_dut(input string tag, input int stg, input int d0, input int d1, input int d2,
                            input logic [2:0] ro, input logic [2:0] ce, input logic [2:0] tk,
                            input logic rdy);
      logic [2:0] e_ro, e_ce, e_tk;
      logic       e_rdy;
      int         dv[3];
      int         t, rel, u;
      dv[0] = imax1(d0); dv[1] = imax1(d1); dv[2] = imax1(d2);
      e_ro = 3'b111; e_ce = 3'b000; e_tk = 3'b000; e_rdy = 1'b0;
      if (start >= 0) begin
         t = edge_n - start;
         for (int k = 0; k < 3; k++) begin
            rel = RC + k * stg;
            if (t >= rel) begin
               u       = t - rel;
               e_ro[k] = 1'b0;
               e_ce[k] = (u >= 1) && (u % dv[k] == 0);
               e_tk[k] = ((u / dv[k]) % 2) == 1;
            end
         end
         e_rdy = (t >= RC + 2 * stg);
      end
      vectors++;
      assert (ro === e_ro) else begin
         miscompares++;
         $error("FAIL %s reset_out @edge %0d: observed %b expected %b", tag, edge_n, ro, e_ro);
      end
      vectors++;
      assert (ce === e_ce) else begin
         miscompares++;
         $error("FAIL %s ce @edge %0d: observed %b expected %b", tag, edge_n, ce, e_ce);
      end
      vectors++;
      assert (tk === e_tk) else begin
         miscompares++;
         $error("FAIL %s tick @edge %0d: observed %b expected %b", tag, edge_n, tk, e_tk);
      end
      vectors++;
      assert (rdy === e_rdy) else begin
         miscompares++;
         $error("FAIL %s ready @edge %0d: observed %b expected %b", tag, edge_n, rdy, e_rdy);
      end
   endtask

   task automatic step(input logic rst_i, input logic lk_i, input logic sr_i);
      reset            = rst_i;
      bus_a.locked     = lk_i;
      bus_a.soft_reset = sr_i;
      bus_b.locked     = lk_i;
      bus_b.soft_reset = sr_i;
      @(posedge clk);
      edge_n++;
      if (rst_i)                 start = -1;
      else if (start < 0) begin
         if (lk_i && !sr_i)      start = edge_n;
      end else if (!lk_i || sr_i) start = -1;
      #1;
      check_dut("a", STG, 1, 2, 3, bus_a.reset_out, bus_a.ce, bus_a.tick, bus_a.ready);
      check_dut("b", 0,   0, 2, 3, bus_b.reset_out, bus_b.ce, bus_b.tick, bus_b.ready);
   endtask

   // Run n locked edges, noting the first edge each milestone is seen on the outputs.
   task automatic run_watch(input int n, output int f0, output int f1, output int rdy_e,
                            output int ce2_e, output int rdyb_e);
      f0 = -1; f1 = -1; rdy_e = -1; ce2_e = -1; rdyb_e = -1;
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b1, 1'b0);
         if (f0 < 0 && bus_a.reset_out[0] === 1'b0) f0 = edge_n;
         if (f1 < 0 && bus_a.reset_out[1] === 1'b0) f1 = edge_n;
         if (rdy_e < 0 && bus_a.ready === 1'b1)     rdy_e = edge_n;
         if (ce2_e < 0 && bus_a.ce[2] === 1'b1)     ce2_e = edge_n;
         if (rdyb_e < 0 && bus_b.ready === 1'b1)    rdyb_e = edge_n;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0, f0, f1, rdy_e, ce2_e, rdyb_e, soft_e, guard;
      logic lk, sr, rs;

      // reset with lock low
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk_int("reset_out after reset", int'(bus_a.reset_out), 7);

      // first lock: staggered release, then RUN divider patterns
      e0 = edge_n + 1;
      run_watch(70, f0, f1, rdy_e, ce2_e, rdyb_e);
      chk_int("first release ch0", f0, e0 + 8);
      chk_int("first release ch1", f1, e0 + 10);
      chk_int("first ready", rdy_e, e0 + 12);
      chk_int("first ce2", ce2_e, e0 + 15);
      chk_int("zero-stagger ready", rdyb_e, e0 + 8);

      // lock loss in RUN clears everything on the next edge
      step(1'b0, 1'b0, 1'b0);
      chk_int("lock loss reset_out", int'(bus_a.reset_out), 7);
      chk_int("lock loss ready", int'(bus_a.ready), 0);

      // relock, dip during HOLD at E0+5, hold count must restart
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      e0 = edge_n + 1;
      run_watch(40, f0, f1, rdy_e, ce2_e, rdyb_e);
      chk_int("relock release ch0", f0, e0 + 8);
      chk_int("relock release ch1", f1, e0 + 10);
      chk_int("relock ready", rdy_e, e0 + 12);
      chk_int("relock ce2", ce2_e, e0 + 15);

      // soft reset pulse in RUN with lock held
      step(1'b0, 1'b1, 1'b1);
      soft_e = edge_n;
      chk_int("soft abort reset_out", int'(bus_a.reset_out), 7);
      run_watch(30, f0, f1, rdy_e, ce2_e, rdyb_e);
      chk_int("soft restart ch0", f0, soft_e + 9);
      chk_int("soft restart ready", rdy_e, soft_e + 13);

      // soft reset coincident with the reset_out[1] release edge
      step(1'b0, 1'b0, 1'b0);
      guard = 0;
      while (!(start >= 0 && edge_n - start == RC + STG - 1) && guard < 50) begin
         step(1'b0, 1'b1, 1'b0);
         guard++;
      end
      chk_int("reach ch1 release edge", int'(guard < 50), 1);
      step(1'b0, 1'b1, 1'b1);
      chk_int("soft wins ch1 release", int'(bus_a.reset_out), 7);
      run_watch(20, f0, f1, rdy_e, ce2_e, rdyb_e);

      // randomized lock drops, soft resets and occasional hard reset
      for (int i = 0; i < 700; i++) begin
         lk = ($urandom_range(0, 39) != 0);
         sr = ($urandom_range(0, 59) == 0);
         rs = ($urandom_range(0, 249) == 0);
         step(rs, lk, sr);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
